// File: rtl/calc2_req_sched.sv
// calc2_req_sched: four-port request capture, per-port queues and arbitration
// in front of one shared pipelined calc2 ALU. Completions and local answers
// (invalid command, queue full) are routed back to the requesting port.
// Latency: cmd at T, op2 at T+1 -> earliest alu_valid at T+2; local response
// at T+2; completion at D -> out_resp at D+1.
// Backpressure: dispatch only while alu_ready=1; a full queue rejects (11).
// Ports: c_clk/reset (sync, active-high); req_cmd_in/req_data_in/req_tag_in
// (four packed requester lanes); alu_* dispatch and completion; out_resp/
// out_data/out_tag (four packed one-cycle response lanes).
// Build option: define CALC2_SCHED_PRIO_EN to give port 0 strict priority
// over round-robin among ports 1-3; undefined gives plain 4-way round-robin.
module calc2_req_sched #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                c_clk,
  input  logic                reset,
  input  logic [15:0]         req_cmd_in,
  input  logic [4*DATA_W-1:0] req_data_in,
  input  logic [7:0]          req_tag_in,
  input  logic                alu_ready,
  output logic                alu_valid,
  output logic [3:0]          alu_cmd,
  output logic [DATA_W-1:0]   alu_op1,
  output logic [DATA_W-1:0]   alu_op2,
  output logic [3:0]          alu_id,
  input  logic                alu_done,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_ovf,
  input  logic [3:0]          alu_id_in,
  output logic [7:0]          out_resp,
  output logic [4*DATA_W-1:0] out_data,
  output logic [7:0]          out_tag
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {S_IDLE, S_OP2} cap_st_e;
  typedef struct packed {
    logic [3:0]        cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [1:0]        tag;
  } entry_t;

  function automatic logic cmd_valid(input logic [3:0] c);
    return (c == 4'h1) || (c == 4'h2) || (c == 4'h5) || (c == 4'h6);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] v);
    return (v == PW'(FIFO_DEPTH - 1)) ? '0 : v + PW'(1);
  endfunction

  cap_st_e           cap_st_q  [4];
  logic [3:0]        cap_cmd_q [4];
  logic [DATA_W-1:0] cap_op1_q [4];
  logic [1:0]        cap_tag_q [4];
  entry_t            fifo_q    [4][FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q  [4];
  logic [PW-1:0]     rd_ptr_q  [4];
  logic [CW-1:0]     cnt_q     [4];
  logic [1:0]        rr_q, rr_d;
  logic              loc_vld_q [4], loc_vld_d [4];
  logic [1:0]        loc_code_q[4], loc_code_d[4];
  logic [1:0]        loc_tag_q [4], loc_tag_d [4];
  logic [7:0]          out_resp_d, out_tag_d;
  logic [4*DATA_W-1:0] out_data_d;

  entry_t     incoming [4];
  logic [3:0] want_push, empty, full, elig, gnt, pop_fifo, bypass, push_acc, loc_new;
  logic [1:0] loc_new_code [4];
  logic       gnt_vld;
  logic [1:0] gnt_port, scan_idx;
  entry_t     gnt_ent;

  // Request completing its OP2 cycle counts as eligible, so an empty queue
  // can be bypassed straight to the ALU register.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      incoming[p].cmd = cap_cmd_q[p];
      incoming[p].op1 = cap_op1_q[p];
      incoming[p].op2 = req_data_in[DATA_W*p +: DATA_W];
      incoming[p].tag = cap_tag_q[p];
      want_push[p] = (cap_st_q[p] == S_OP2) && cmd_valid(cap_cmd_q[p]);
      empty[p]     = (cnt_q[p] == '0);
      full[p]      = (cnt_q[p] == CW'(FIFO_DEPTH));
      elig[p]      = !empty[p] || want_push[p];
    end
  end

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_port = 2'd0;
    scan_idx = 2'd0;
    if (alu_ready) begin
`ifdef CALC2_SCHED_PRIO_EN
      if (elig[0]) begin
        gnt_vld  = 1'b1;
        gnt_port = 2'd0;
      end
      for (int i = 0; i < 4; i++) begin
        scan_idx = rr_q + 2'(i);
        if (!gnt_vld && scan_idx != 2'd0 && elig[scan_idx]) begin
          gnt_vld  = 1'b1;
          gnt_port = scan_idx;
        end
      end
`else
      for (int i = 0; i < 4; i++) begin
        scan_idx = rr_q + 2'(i);
        if (!gnt_vld && elig[scan_idx]) begin
          gnt_vld  = 1'b1;
          gnt_port = scan_idx;
        end
      end
`endif
    end
    gnt  = gnt_vld ? (4'b0001 << gnt_port) : 4'b0000;
    rr_d = rr_q;
`ifdef CALC2_SCHED_PRIO_EN
    // Port 0 wins by priority, so it does not move the ports 1-3 rotation.
    if (gnt_vld && gnt_port != 2'd0) rr_d = gnt_port + 2'd1;
`else
    if (gnt_vld) rr_d = gnt_port + 2'd1;
`endif
    gnt_ent = empty[gnt_port] ? incoming[gnt_port] : fifo_q[gnt_port][rd_ptr_q[gnt_port]];
  end

  always_comb begin
    out_resp_d = '0;
    out_data_d = '0;
    out_tag_d  = '0;
    for (int p = 0; p < 4; p++) begin
      pop_fifo[p] = gnt[p] && !empty[p];
      bypass[p]   = gnt[p] && empty[p];
      push_acc[p] = want_push[p] && !bypass[p] && (!full[p] || pop_fifo[p]);
      loc_new[p]  = (cap_st_q[p] == S_OP2) &&
                    (!cmd_valid(cap_cmd_q[p]) || (want_push[p] && !bypass[p] && full[p] && !pop_fifo[p]));
      loc_new_code[p] = cmd_valid(cap_cmd_q[p]) ? 2'b11 : 2'b10;
      loc_vld_d[p]  = loc_vld_q[p];
      loc_code_d[p] = loc_code_q[p];
      loc_tag_d[p]  = loc_tag_q[p];
      if (alu_done && alu_id_in[3:2] == 2'(p)) begin
        // Completion owns the lane; a simultaneous local answer is parked.
        out_resp_d[2*p +: 2]           = alu_ovf ? 2'b10 : 2'b01;
        out_data_d[DATA_W*p +: DATA_W] = alu_result;
        out_tag_d[2*p +: 2]            = alu_id_in[1:0];
        if (loc_new[p]) begin
          loc_vld_d[p]  = 1'b1;
          loc_code_d[p] = loc_new_code[p];
          loc_tag_d[p]  = cap_tag_q[p];
        end
      end else if (loc_new[p]) begin
        // A fresh local answer supersedes any parked one.
        out_resp_d[2*p +: 2] = loc_new_code[p];
        out_tag_d[2*p +: 2]  = cap_tag_q[p];
        loc_vld_d[p]         = 1'b0;
      end else if (loc_vld_q[p]) begin
        out_resp_d[2*p +: 2] = loc_code_q[p];
        out_tag_d[2*p +: 2]  = loc_tag_q[p];
        loc_vld_d[p]         = 1'b0;
      end
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int p = 0; p < 4; p++) begin
        cap_st_q[p]   <= S_IDLE;
        cap_cmd_q[p]  <= '0;
        cap_op1_q[p]  <= '0;
        cap_tag_q[p]  <= '0;
        wr_ptr_q[p]   <= '0;
        rd_ptr_q[p]   <= '0;
        cnt_q[p]      <= '0;
        loc_vld_q[p]  <= 1'b0;
        loc_code_q[p] <= '0;
        loc_tag_q[p]  <= '0;
      end
      rr_q      <= 2'd0;
      alu_valid <= 1'b0;
      alu_cmd   <= '0;
      alu_op1   <= '0;
      alu_op2   <= '0;
      alu_id    <= '0;
      out_resp  <= '0;
      out_data  <= '0;
      out_tag   <= '0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        case (cap_st_q[p])
          S_IDLE: begin
            if (req_cmd_in[4*p +: 4] != 4'h0) begin
              cap_cmd_q[p] <= req_cmd_in[4*p +: 4];
              cap_op1_q[p] <= req_data_in[DATA_W*p +: DATA_W];
              cap_tag_q[p] <= req_tag_in[2*p +: 2];
              cap_st_q[p]  <= S_OP2;
            end
          end
          default: cap_st_q[p] <= S_IDLE;
        endcase
        if (push_acc[p]) begin
          fifo_q[p][wr_ptr_q[p]] <= incoming[p];
          wr_ptr_q[p]            <= ptr_inc(wr_ptr_q[p]);
        end
        if (pop_fifo[p]) rd_ptr_q[p] <= ptr_inc(rd_ptr_q[p]);
        if (push_acc[p] && !pop_fifo[p])      cnt_q[p] <= cnt_q[p] + CW'(1);
        else if (!push_acc[p] && pop_fifo[p]) cnt_q[p] <= cnt_q[p] - CW'(1);
        loc_vld_q[p]  <= loc_vld_d[p];
        loc_code_q[p] <= loc_code_d[p];
        loc_tag_q[p]  <= loc_tag_d[p];
      end
      rr_q      <= rr_d;
      alu_valid <= gnt_vld;
      alu_cmd   <= gnt_vld ? gnt_ent.cmd : '0;
      alu_op1   <= gnt_vld ? gnt_ent.op1 : '0;
      alu_op2   <= gnt_vld ? gnt_ent.op2 : '0;
      alu_id    <= gnt_vld ? {gnt_port, gnt_ent.tag} : '0;
      out_resp  <= out_resp_d;
      out_data  <= out_data_d;
      out_tag   <= out_tag_d;
    end
  end
endmodule

// File: tb/tb_calc2_req_sched.sv
// Testbench for calc2_req_sched: directed scenarios followed by randomized
// traffic, every cycle compared against a queue-based reference model.
module tb_calc2_req_sched;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic            c_clk = 1'b0;
  logic            reset;
  logic [15:0]     req_cmd_in;
  logic [4*DW-1:0] req_data_in;
  logic [7:0]      req_tag_in;
  logic            alu_ready;
  logic            alu_valid;
  logic [3:0]      alu_cmd;
  logic [DW-1:0]   alu_op1, alu_op2;
  logic [3:0]      alu_id;
  logic            alu_done;
  logic [DW-1:0]   alu_result;
  logic            alu_ovf;
  logic [3:0]      alu_id_in;
  logic [7:0]      out_resp;
  logic [4*DW-1:0] out_data;
  logic [7:0]      out_tag;

  always #5 c_clk = ~c_clk;

  calc2_req_sched #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .c_clk(c_clk), .reset(reset),
    .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .alu_ready(alu_ready), .alu_valid(alu_valid), .alu_cmd(alu_cmd),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_id(alu_id),
    .alu_done(alu_done), .alu_result(alu_result), .alu_ovf(alu_ovf), .alu_id_in(alu_id_in),
    .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag)
  );

  typedef struct packed {
    logic [3:0]    cmd;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [1:0]    tag;
  } ent_t;
  typedef struct packed {
    logic [3:0]    id;
    logic [DW-1:0] res;
  } cmp_t;

  // Reference model: list of outstanding requests per port (queued plus the
  // one arriving this cycle), capture flags, rotation pointer, parked answers.
  ent_t          mq [4][$];
  cmp_t          comp_q [$];
  bit            m_busy [4];
  logic [3:0]    m_cmd  [4];
  logic [DW-1:0] m_op1  [4];
  logic [1:0]    m_tag  [4];
  int            m_rr;
  bit            m_lv   [4];
  logic [1:0]    m_lc   [4];
  logic [1:0]    m_lt   [4];

  logic            exp_v;
  logic [3:0]      exp_cmd, exp_id;
  logic [DW-1:0]   exp_op1, exp_op2;
  logic [7:0]      exp_resp, exp_tag;
  logic [4*DW-1:0] exp_data;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_valid(input logic [3:0] c);
    return (c == 4'h1) || (c == 4'h2) || (c == 4'h5) || (c == 4'h6);
  endfunction

  function automatic logic [DW-1:0] alu_res(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (c)
      4'h1:    return a + b;
      4'h2:    return a - b;
      4'h5:    return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  task automatic model_step();
    ent_t e;
    int   g;
    int   pp;
    bit   ln;
    logic [1:0] lc;
    exp_v = 1'b0; exp_cmd = '0; exp_op1 = '0; exp_op2 = '0; exp_id = '0;
    exp_resp = '0; exp_data = '0; exp_tag = '0;
    if (reset) begin
      for (int p = 0; p < 4; p++) begin
        mq[p].delete();
        m_busy[p] = 1'b0; m_lv[p] = 1'b0;
      end
      m_rr = 0;
      comp_q.delete();
      return;
    end
    for (int p = 0; p < 4; p++) begin
      if (m_busy[p] && is_valid(m_cmd[p])) begin
        e.cmd = m_cmd[p]; e.op1 = m_op1[p]; e.op2 = req_data_in[DW*p +: DW]; e.tag = m_tag[p];
        mq[p].push_back(e);
      end
    end
    g = -1;
    if (alu_ready) begin
`ifdef CALC2_SCHED_PRIO_EN
      if (mq[0].size() > 0) g = 0;
      for (int k = 0; k < 4; k++) begin
        pp = (m_rr + k) % 4;
        if (g < 0 && pp != 0 && mq[pp].size() > 0) g = pp;
      end
`else
      for (int k = 0; k < 4; k++) begin
        pp = (m_rr + k) % 4;
        if (g < 0 && mq[pp].size() > 0) g = pp;
      end
`endif
    end
    if (g >= 0) begin
      e = mq[g].pop_front();
      exp_v = 1'b1; exp_cmd = e.cmd; exp_op1 = e.op1; exp_op2 = e.op2;
      exp_id = {2'(g), e.tag};
      comp_q.push_back('{id: exp_id, res: alu_res(e.cmd, e.op1, e.op2)});
`ifdef CALC2_SCHED_PRIO_EN
      if (g != 0) m_rr = (g + 1) % 4;
`else
      m_rr = (g + 1) % 4;
`endif
    end
    for (int p = 0; p < 4; p++) begin
      ln = 1'b0; lc = 2'b00;
      if (m_busy[p]) begin
        if (!is_valid(m_cmd[p])) begin
          ln = 1'b1; lc = 2'b10;
        end else if (mq[p].size() > DEPTH) begin
          void'(mq[p].pop_back());
          ln = 1'b1; lc = 2'b11;
        end
      end
      if (alu_done && alu_id_in[3:2] == 2'(p)) begin
        exp_resp[2*p +: 2]   = alu_ovf ? 2'b10 : 2'b01;
        exp_data[DW*p +: DW] = alu_result;
        exp_tag[2*p +: 2]    = alu_id_in[1:0];
        if (ln) begin m_lv[p] = 1'b1; m_lc[p] = lc; m_lt[p] = m_tag[p]; end
      end else if (ln) begin
        exp_resp[2*p +: 2] = lc; exp_tag[2*p +: 2] = m_tag[p]; m_lv[p] = 1'b0;
      end else if (m_lv[p]) begin
        exp_resp[2*p +: 2] = m_lc[p]; exp_tag[2*p +: 2] = m_lt[p]; m_lv[p] = 1'b0;
      end
      if (m_busy[p]) begin
        m_busy[p] = 1'b0;
      end else if (req_cmd_in[4*p +: 4] != 4'h0) begin
        m_busy[p] = 1'b1;
        m_cmd[p]  = req_cmd_in[4*p +: 4];
        m_op1[p]  = req_data_in[DW*p +: DW];
        m_tag[p]  = req_tag_in[2*p +: 2];
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge c_clk);
    #1;
    chk("alu_valid", 128'(alu_valid), 128'(exp_v));
    chk("alu_cmd",   128'(alu_cmd),   128'(exp_cmd));
    chk("alu_op1",   128'(alu_op1),   128'(exp_op1));
    chk("alu_op2",   128'(alu_op2),   128'(exp_op2));
    chk("alu_id",    128'(alu_id),    128'(exp_id));
    chk("out_resp",  128'(out_resp),  128'(exp_resp));
    chk("out_data",  128'(out_data),  128'(exp_data));
    chk("out_tag",   128'(out_tag),   128'(exp_tag));
  endtask

  task automatic clr_in();
    req_cmd_in = '0; req_data_in = '0; req_tag_in = '0;
    alu_done = 1'b0; alu_id_in = '0; alu_result = '0; alu_ovf = 1'b0;
  endtask

  task automatic set_port(input int p, input logic [3:0] c, input logic [DW-1:0] d, input logic [1:0] t);
    req_cmd_in[4*p +: 4]   = c;
    req_data_in[DW*p +: DW] = d;
    req_tag_in[2*p +: 2]   = t;
  endtask

  task automatic do_reset();
    clr_in();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  logic [3:0] cmd_tab [6] = '{4'h1, 4'h2, 4'h5, 4'h6, 4'h3, 4'hC};
`ifdef CALC2_SCHED_PRIO_EN
  int wave_seq [8] = '{0, 1, 0, 2, 3, 1, 2, 3};
`else
  int wave_seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif

  initial begin
    int   cnt;
    cmp_t c;
    clr_in();
    alu_ready = 1'b0;
    reset = 1'b1;
    do_reset();
    chk("rst_valid", 128'(alu_valid), 128'(0));
    chk("rst_resp",  128'(out_resp),  128'(0));

    // Single add on port 0, then its completion.
    alu_ready = 1'b1;
    set_port(0, 4'h1, 32'h30, 2'd1);
    cycle();
    set_port(0, 4'h0, 32'h20, 2'd0);
    cycle();
    chk("t1_valid", 128'(alu_valid), 128'(1));
    chk("t1_cmd",   128'(alu_cmd),   128'(4'h1));
    chk("t1_op1",   128'(alu_op1),   128'(32'h30));
    chk("t1_op2",   128'(alu_op2),   128'(32'h20));
    chk("t1_id",    128'(alu_id),    128'(4'b0001));
    clr_in();
    alu_done = 1'b1; alu_id_in = 4'b0001; alu_result = 32'h50;
    comp_q.delete();
    cycle();
    chk("t1_resp", 128'(out_resp[1:0]), 128'(2'b01));
    chk("t1_data", 128'(out_data[31:0]), 128'(32'h50));
    chk("t1_tag",  128'(out_tag[1:0]),  128'(2'd1));
    clr_in();
    cycle();

    // Two waves from all four ports.
    do_reset();
    alu_ready = 1'b1;
    for (int p = 0; p < 4; p++) set_port(p, 4'h1, 32'(p + 1), 2'(p));
    cycle();
    for (int p = 0; p < 4; p++) set_port(p, 4'h0, 32'(p + 16), 2'd0);
    cycle();
    for (int i = 0; i < 8; i++) begin
      chk("wave_vld",  128'(alu_valid),   128'(1));
      chk("wave_port", 128'(alu_id[3:2]), 128'(wave_seq[i]));
      clr_in();
      if (i == 0) for (int p = 0; p < 4; p++) set_port(p, 4'h2, 32'(p + 40), 2'(3 - p));
      if (i == 1) for (int p = 0; p < 4; p++) set_port(p, 4'h0, 32'(p + 50), 2'd0);
      cycle();
    end
    comp_q.delete();

    // Invalid command on port 1.
    clr_in();
    set_port(1, 4'h3, 32'h11, 2'd2);
    cycle();
    set_port(1, 4'h0, 32'h22, 2'd0);
    cycle();
    chk("t3_resp",  128'(out_resp[3:2]),  128'(2'b10));
    chk("t3_tag",   128'(out_tag[3:2]),   128'(2'd2));
    chk("t3_data",  128'(out_data[63:32]), 128'(0));
    chk("t3_valid", 128'(alu_valid),      128'(0));
    clr_in();
    cycle();

    // Queue-full rejection on port 2 while the ALU stalls.
    alu_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      set_port(2, 4'h1, 32'(r), 2'(r));
      cycle();
      set_port(2, 4'h0, 32'(r + 100), 2'd0);
      cycle();
    end
    chk("t4_rej",     128'(out_resp[5:4]), 128'(2'b11));
    chk("t4_rej_tag", 128'(out_tag[5:4]),  128'(2'd2));
    clr_in();
    alu_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      cnt += int'(alu_valid);
    end
    chk("t4_disp_cnt", 128'(cnt), 128'(2));
    comp_q.delete();

    // Completion collides with a local answer on port 1.
    set_port(1, 4'h3, 32'h5, 2'd3);
    cycle();
    set_port(1, 4'h0, 32'h6, 2'd0);
    alu_done = 1'b1; alu_id_in = 4'b0110; alu_result = 32'h77; alu_ovf = 1'b0;
    cycle();
    chk("t5_alu_resp", 128'(out_resp[3:2]),  128'(2'b01));
    chk("t5_alu_data", 128'(out_data[63:32]), 128'(32'h77));
    chk("t5_alu_tag",  128'(out_tag[3:2]),   128'(2'd2));
    clr_in();
    cycle();
    chk("t5_loc_resp", 128'(out_resp[3:2]),  128'(2'b10));
    chk("t5_loc_tag",  128'(out_tag[3:2]),   128'(2'd3));
    chk("t5_loc_data", 128'(out_data[63:32]), 128'(0));

    // Reset with queued entries and a capture in progress.
    alu_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      set_port(0, 4'h2, 32'(r + 7), 2'(r));
      cycle();
      set_port(0, 4'h0, 32'(r + 9), 2'd0);
      cycle();
    end
    set_port(3, 4'h5, 32'h1, 2'd1);
    cycle();
    set_port(3, 4'h0, 32'h2, 2'd0);
    reset = 1'b1;
    cycle();
    chk("t6_rst_valid", 128'(alu_valid), 128'(0));
    chk("t6_rst_resp",  128'(out_resp),  128'(0));
    chk("t6_rst_data",  128'(out_data),  128'(0));
    reset = 1'b0;
    clr_in();
    alu_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      cnt += int'(alu_valid) + int'(out_resp != 8'h00);
    end
    chk("t6_quiet", 128'(cnt), 128'(0));

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 399) == 0);
      alu_ready = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < 4; p++) begin
        if (m_busy[p])
          set_port(p, 4'($urandom), $urandom, 2'($urandom));
        else if ($urandom_range(0, 2) == 0)
          set_port(p, cmd_tab[$urandom_range(0, 5)], $urandom, 2'($urandom));
        else
          set_port(p, 4'h0, $urandom, 2'($urandom));
      end
      if (comp_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        c = comp_q.pop_front();
        alu_done = 1'b1; alu_id_in = c.id; alu_result = c.res;
        alu_ovf = 1'($urandom_range(0, 1));
      end else begin
        alu_done = 1'b0; alu_id_in = 4'($urandom); alu_result = $urandom;
        alu_ovf = 1'($urandom_range(0, 1));
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
